cix_seq: RTL and testbench
==========================

Name: cix_seq

Overview:
- Multi-cycle bit-count engine for operands wider than one bit-count slice.
- Holds a single `cix` slice of order ORDER and feeds it one 2**ORDER-bit chunk of the latched operand per cycle, summing the per-chunk counts.
- Supports clz/ctz early termination, valid/ready on both sides.
- Sits in the ALU as the shared bit-count resource where a full-width combinational `cix` is too large or too slow.

Parameters:
- ORDER, 3: log2 of slice width; slice S = 2**ORDER bits.
- STEPS, 2: log2 of chunk count; N = 2**STEPS chunks; operand width W = 2**(ORDER+STEPS), 32 by default.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- clz  input  1  op select, count from MSB.
- ctz  input  1  op select, count from LSB.
- inv  input  1  invert operand, counting ones instead of zeros.
- in  input  W  operand.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer takes result.
- out  output  ORDER+STEPS+1  count, range 0..W.
- zero  output  1  whole (possibly inverted) operand is all zeros (out == W).
- busy  output  1  state != IDLE.

Behaviour:
- Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, out=0, zero=0, busy=0, accumulator and chunk index cleared. Any in-flight operation is discarded.
- Op encoding:
  - clz only: leading zeros. ctz only: trailing zeros.
  - clz and ctz: zero count (popcount of ~in).
  - inv=1 turns each into clo / cto / popcount.
  - clz=ctz=0: NOP, result 0, zero=0, occupies 1 RUN cycle.
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid: latch op, latch opnd = inv ? ~in : in, acc=0, allz=1. Chunk index idx = N-1 if clz-only, else 0. Go to RUN.
- RUN: in_ready=0. The slice sees opnd[idx*S +: S] with clz/ctz tied to the latched op bits. Each cycle, with slice outputs (c, z):
  - acc += c; allz &= z.
  - Early stop: exactly one of clz/ctz set and z=0, i.e. the first chunk containing a one bit ends the scan.
  - Last chunk: idx == 0 for clz-only, idx == N-1 otherwise.
  - On early stop or last chunk: register out=acc+c, zero=allz&z, go to DONE. Otherwise step idx by -1 (clz-only) or +1.
- Latency: accept edge to out_valid = k cycles, where k = chunks scanned (1..N). Popcount and zero count always take N cycles.
- DONE: out_valid=1. out and zero are held stable until out_ready=1, then go to IDLE the next cycle. One-cycle bubble before the next accept; in_ready=0 in DONE.
- Width rules: acc is ORDER+STEPS+1 bits. The maximum sum is W, so acc never overflows.
- Inputs change freely outside the IDLE accept cycle; only the latched copy is used.
- in_valid in RUN or DONE is ignored; the requester must hold it until in_ready.
- No combinational path from in_valid to in_ready or from out_ready to out_valid.

Test Plan:
- Reset mid-RUN: assert reset during a popcount of 0xFFFFFFFF at cycle 2 -> same cycle: out_valid=0, in_ready=1, busy=0. Next request completes normally.
- clz, inv=0, in=0x00010000 -> chunk3 z=1 (c=8), chunk2 c=7 non-zero -> out=15, zero=0, out_valid 2 cycles after accept.
- ctz, inv=0, in=0x00000000 -> out=32, zero=1 after 4 cycles. clz, in=0x80000000 -> out=0 after 1 cycle.
- Popcount (clz=ctz=inv=1), in=0xF0F00001 -> out=9, zero=0, exactly 4 RUN cycles, no early stop. Zero count, in=0xFFFFFFFE -> out=1.
- cto (ctz, inv=1), in=0x000000FF -> chunk0 all ones (c=8), chunk1 c=0 -> out=8 after 2 cycles. NOP op -> out=0 after 1 cycle.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 and changing in -> out/zero stable, in_ready=0, nothing accepted. Release out_ready -> one bubble, then next request accepted.

Source files
------------

// File: rtl/cix_seq.sv
// Multi-cycle bit-count engine: one 2**ORDER-bit slice walks the latched operand
// chunk by chunk, accumulating leading/trailing/zero counts with early termination.
module cix_seq #(
   parameter int ORDER = 3,
   parameter int STEPS = 2
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic                                clz,
   input  logic                                ctz,
   input  logic                                inv,
   input  logic [2**(ORDER+STEPS)-1:0]         in,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [ORDER+STEPS:0]                out,
   output logic                                zero,
   output logic                                busy
);

   localparam int S   = 2**ORDER;
   localparam int N   = 2**STEPS;
   localparam int W   = 2**(ORDER+STEPS);
   localparam int CW  = ORDER+STEPS+1;
   localparam int CSW = ORDER+1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state, state_nxt;
   logic              op_clz, op_ctz;
   logic [W-1:0]      opnd;
   logic [CW-1:0]     acc;
   logic              allz;
   logic [STEPS-1:0]  idx;

   logic [S-1:0]      chunk;
   logic [CSW-1:0]    sc;
   logic              sz;
   logic [CW-1:0]     sum;
   logic              nop, single, lead, last, finish;

   // Slice: counts within the current chunk, tied to the latched op bits
   always_comb begin
      chunk = S'(opnd >> (int'(idx) * S));
      sz    = (chunk == '0);
      sc    = '0;
      if (op_clz && !op_ctz) begin
         sc = CSW'(S);
         for (int i = 0; i < S; i++)
            if (chunk[i]) sc = CSW'(S - 1 - i);
      end else if (op_ctz && !op_clz) begin
         sc = CSW'(S);
         for (int i = S - 1; i >= 0; i--)
            if (chunk[i]) sc = CSW'(i);
      end else if (op_clz && op_ctz) begin
         for (int i = 0; i < S; i++)
            if (!chunk[i]) sc = sc + 1'b1;
      end
   end

   always_comb begin
      nop    = !op_clz && !op_ctz;
      single = op_clz ^ op_ctz;
      lead   = op_clz && !op_ctz;
      last   = lead ? (idx == '0) : (idx == STEPS'(N - 1));
      finish = nop || last || (single && !sz);
      sum    = acc + CW'(sc);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) state_nxt = RUN;
         end
         RUN: begin
            if (finish) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         op_clz <= 1'b0;
         op_ctz <= 1'b0;
         opnd   <= '0;
         acc    <= '0;
         allz   <= 1'b0;
         idx    <= '0;
         out    <= '0;
         zero   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               op_clz <= clz;
               op_ctz <= ctz;
               opnd   <= inv ? ~in : in;
               acc    <= '0;
               allz   <= 1'b1;
               idx    <= (clz && !ctz) ? STEPS'(N - 1) : '0;
            end
            RUN: begin
               if (finish) begin
                  // NOP reports a plain zero count and never flags all-zero
                  out  <= nop ? '0 : sum;
                  zero <= nop ? 1'b0 : (allz & sz);
               end else begin
                  acc  <= sum;
                  allz <= allz & sz;
                  idx  <= lead ? idx - 1'b1 : idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cix_seq.sv
// Scoreboard bench for cix_seq: expected count, zero flag and latency are queued
// at accept time and checked when out_valid rises.
module tb_cix_seq;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid, in_ready;
   logic        clz, ctz, inv;
   logic [31:0] in;
   logic        out_valid, out_ready;
   logic [5:0]  out;
   logic        zero, busy;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [5:0] out;
      logic       zero;
      int         k;
   } exp_t;

   exp_t sbq[$];

   cix_seq dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .clz(clz), .ctz(ctz), .inv(inv), .in(in), .out_valid(out_valid),
      .out_ready(out_ready), .out(out), .zero(zero), .busy(busy)
   );

   always #5 clock = ~clock;

   function automatic exp_t model(logic c, logic t, logic v, logic [31:0] x);
      exp_t r;
      logic [31:0] o;
      int lz, tz, zc;
      o  = v ? ~x : x;
      lz = 32; tz = 32; zc = 0;
      for (int i = 0; i < 32; i++) if (o[i]) lz = 31 - i;
      for (int i = 31; i >= 0; i--) if (o[i]) tz = i;
      for (int i = 0; i < 32; i++) if (!o[i]) zc++;
      r.zero = (o == 32'd0);
      if (!c && !t) begin
         r.out = 6'd0; r.zero = 1'b0; r.k = 1;
      end else if (c && !t) begin
         r.out = 6'(lz); r.k = (lz >= 32) ? 4 : lz / 8 + 1;
      end else if (!c && t) begin
         r.out = 6'(tz); r.k = (tz >= 32) ? 4 : tz / 8 + 1;
      end else begin
         r.out = 6'(zc); r.k = 4;
      end
      return r;
   endfunction

   // Called at a negedge; returns at the negedge right after the accept edge
   task automatic send(input logic c, input logic t, input logic v, input logic [31:0] x);
      int w;
      w = 0;
      while (!in_ready && w < 50) begin @(negedge clock); w++; end
      checks++;
      if (!in_ready) begin
         failures++;
         $display("FAIL send_ready: in_ready=%0b required 1", in_ready);
      end
      clz = c; ctz = t; inv = v; in = x; in_valid = 1'b1;
      sbq.push_back(model(c, t, v, x));
      @(posedge clock);
      @(negedge clock);
      in_valid = 1'b0;
      in = $urandom;
      clz = $urandom; ctz = $urandom; inv = $urandom;
   endtask

   task automatic receive(input string name, input logic release_now);
      exp_t e;
      int cyc;
      cyc = 0;
      while (!out_valid && cyc <= 40) begin @(negedge clock); cyc++; end
      e = sbq.pop_front();
      checks++;
      if (!out_valid) begin
         failures++;
         $display("FAIL %s_timeout: out_valid never rose", name);
         return;
      end
      if (cyc != e.k) begin
         failures++;
         $display("FAIL %s_latency: got %0d cycles required %0d", name, cyc, e.k);
      end
      checks++;
      if (out !== e.out) begin
         failures++;
         $display("FAIL %s_out: got %0d required %0d", name, out, e.out);
      end
      checks++;
      if (zero !== e.zero) begin
         failures++;
         $display("FAIL %s_zero: got %0b required %0b", name, zero, e.zero);
      end
      checks++;
      if (in_ready !== 1'b0) begin
         failures++;
         $display("FAIL %s_in_ready_done: got %0b required 0", name, in_ready);
      end
      if (release_now) begin
         out_ready = 1'b1;
         @(negedge clock);
         out_ready = 1'b0;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      clz = 1'b0; ctz = 1'b0; inv = 1'b0; in = '0;
      repeat (2) @(negedge clock);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out !== 6'd0 || zero !== 1'b0) begin
         failures++;
         $display("FAIL reset_state: rdy=%0b vld=%0b busy=%0b out=%0d zero=%0b required 1 0 0 0 0",
                  in_ready, out_valid, busy, out, zero);
      end
      reset = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_reset_mid_run;
      send(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
      @(negedge clock);
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
         failures++;
         $display("FAIL midrun_busy: busy=%0b rdy=%0b required 1 0", busy, in_ready);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL midrun_reset: vld=%0b rdy=%0b busy=%0b required 0 1 0",
                  out_valid, in_ready, busy);
      end
      void'(sbq.pop_front());
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      send(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
      receive("after_reset", 1'b1);
   endtask

   task automatic test_clz_ctz;
      send(1'b1, 1'b0, 1'b0, 32'h0001_0000); receive("clz_10000", 1'b1);
      send(1'b0, 1'b1, 1'b0, 32'h0000_0000); receive("ctz_zero", 1'b1);
      send(1'b1, 1'b0, 1'b0, 32'h8000_0000); receive("clz_msb", 1'b1);
      send(1'b0, 1'b1, 1'b1, 32'h0000_00FF); receive("cto_ff", 1'b1);
      send(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF); receive("clo_all", 1'b1);
   endtask

   task automatic test_popcount;
      send(1'b1, 1'b1, 1'b1, 32'hF0F0_0001); receive("popcnt", 1'b1);
      send(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE); receive("zerocnt", 1'b1);
      send(1'b1, 1'b1, 1'b0, 32'h0000_0000); receive("zerocnt_all", 1'b1);
      send(1'b0, 1'b0, 1'b0, 32'h1234_5678); receive("nop", 1'b1);
      send(1'b0, 1'b0, 1'b1, 32'h0000_0000); receive("nop_inv", 1'b1);
   endtask

   task automatic test_backpressure;
      exp_t e;
      send(1'b1, 1'b0, 1'b0, 32'h0000_4000);
      e = sbq[0];
      receive("bp_first", 1'b0);
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in = $urandom; clz = 1'b1; ctz = 1'b1; inv = 1'b0;
         @(negedge clock);
         checks++;
         if (out_valid !== 1'b1 || out !== e.out || zero !== e.zero || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold: vld=%0b out=%0d zero=%0b rdy=%0b required 1 %0d %0b 0",
                     out_valid, out, zero, in_ready, e.out, e.zero);
         end
      end
      clz = 1'b0; ctz = 1'b1; inv = 1'b0; in = 32'h0000_0100;
      out_ready = 1'b1;
      @(negedge clock);
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL bp_bubble: rdy=%0b vld=%0b required 1 0", in_ready, out_valid);
      end
      sbq.push_back(model(1'b0, 1'b1, 1'b0, 32'h0000_0100));
      @(posedge clock);
      @(negedge clock);
      in_valid = 1'b0;
      receive("bp_next", 1'b1);
   endtask

   task automatic test_back_to_back;
      logic [31:0] x;
      for (int i = 0; i < 24; i++) begin
         x = $urandom;
         if (i % 3 == 0) x = x & (32'hFFFF_FFFF >> (i % 32));
         if (i % 4 == 1) x = x & ~(32'hFFFF_FFFF >> (i % 32));
         send(1'($urandom), 1'($urandom), 1'($urandom), x);
         receive("b2b", 1'b1);
      end
   endtask

   initial begin
      test_reset;
      test_reset_mid_run;
      test_clz_ctz;
      test_popcount;
      test_backpressure;
      test_back_to_back;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
